// File: rtl/led_pattern_pkg.sv
// Shared mode codes, FSM encoding and frame generator for the LED pattern engine.
// pattern() works on a fixed MAX_N-bit vector; callers truncate to their LED count.
package led_pattern_pkg;

  localparam int MAX_N = 64;

  localparam logic [2:0] MODE_SHR      = 3'd0;
  localparam logic [2:0] MODE_SHL      = 3'd1;
  localparam logic [2:0] MODE_FILL_R   = 3'd2;
  localparam logic [2:0] MODE_FILL_L   = 3'd3;
  localparam logic [2:0] MODE_DOT_OUT  = 3'd4;
  localparam logic [2:0] MODE_DOT_IN   = 3'd5;
  localparam logic [2:0] MODE_FILL_OUT = 3'd6;
  localparam logic [2:0] MODE_FILL_IN  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Symmetric modes (4..7) light two LEDs per step, so they need half the frames.
  function automatic int frames(input logic [2:0] mode, input int n);
    return mode[2] ? n / 2 : n;
  endfunction

  function automatic logic [MAX_N-1:0] pattern(input logic [2:0] mode, input int k, input int n);
    logic [MAX_N-1:0] f;
    int h;
    f = '0;
    h = n / 2;
    if (k > 0) begin
      for (int i = 0; i < MAX_N; i++) begin
        if (i < n) begin
          case (mode)
            MODE_SHR:      f[i] = (i == n - k);
            MODE_SHL:      f[i] = (i == k - 1);
            MODE_FILL_R:   f[i] = (i >= n - k);
            MODE_FILL_L:   f[i] = (i <= k - 1);
            MODE_DOT_OUT:  f[i] = (i == h - k) || (i == h + k - 1);
            MODE_DOT_IN:   f[i] = (i == n - k) || (i == k - 1);
            MODE_FILL_OUT: f[i] = (i >= h - k) && (i <= h + k - 1);
            default:       f[i] = (i >= n - k) || (i <= k - 1);
          endcase
        end
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: tick every period+1 clocks while run is high; clr restarts the count.
// The count freezes while paused; a shrunk period clears an overrun count without ticking.
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  input  logic             clr,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      // Covers both the normal terminal count and a live period reduction below cnt.
      if (cnt_q >= period) cnt_d = '0;
      else                 cnt_d = cnt_q + DIV_W'(1);
    end
  end

  assign tick = run && !clr && (cnt_q == period);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_pattern_engine.sv
// N-bit LED pattern generator: eight run-time patterns, one-shot/repeat, prescaled steps.
// led/step/done/wrap are registered; a mode change restarts from frame 0 on the same edge.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_i,
  input  logic [2:0]       mode_i,
  input  logic             repeat_i,
  input  logic [DIV_W-1:0] period_i,
  output logic [N-1:0]     led_o,
  output logic             step_o,
  output logic             done_o,
  output logic             wrap_o
);

  localparam int KW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d, k_next;
  logic [2:0]     mode_q;
  logic [N-1:0]   led_q, led_d, frame_next;
  logic           step_q, step_d, done_q, done_d, wrap_q, wrap_d;
  logic           mode_chg, tick;

  assign mode_chg   = (mode_i != mode_q);
  assign k_next     = k_q + KW'(1);
  assign frame_next = N'(pattern(mode_q, int'(k_next), N));

  led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .run    (run_i),
    .period (period_i),
    .clr    (mode_chg),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    led_d   = led_q;
    done_d  = done_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_chg) begin
      state_d = ST_IDLE;
      k_d     = '0;
      led_d   = '0;
      done_d  = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          k_d     = k_next;
          led_d   = frame_next;
          step_d  = 1'b1;
          state_d = (int'(k_next) == frames(mode_q, N)) ? ST_LAST : ST_RUN;
        end
        ST_LAST: begin
          if (repeat_i) begin
            state_d = ST_IDLE;
            k_d     = '0;
            led_d   = '0;
            step_d  = 1'b1;
            wrap_d  = 1'b1;
          end else begin
            // Final frame stays on the LEDs, so no step pulse here.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      mode_q  <= mode_i;
      led_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mode_q  <= mode_i;
      led_q   <= led_d;
      step_q  <= step_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign led_o  = led_q;
  assign step_o = step_q;
  assign done_o = done_q;
  assign wrap_o = wrap_q;

endmodule
